// File: rtl/benes_cfg_loader.sv
// Benes network configuration loader: shadow bank filled over valid/ready, copied atomically to the active bank.
// Optional build macro BENES_CFG_AUTOSWAP_EN: swap on the last word's edge instead of waiting for swap_en.
module benes_cfg_loader #(
    parameter int SIZE       = 32,
    parameter int SWITCH_NUM = SIZE / 2,
    parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [SWITCH_NUM-1:0] cfg_data,
    input  logic                  cfg_last,
    input  logic                  swap_en,
    output logic [SWITCH_NUM-1:0] o_switch_set [0:STAGE_NUM-1],
    output logic                  active_valid,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [0:0]            state_dbg
);

    // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready is registered and cfg_data/cfg_last are only sampled on a transfer.

    localparam int IDX_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE_NUM - 1);

    localparam logic [0:0] LOAD      = 1'b0;
    localparam logic [0:0] WAIT_SWAP = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      cfg_idx;
    logic [SWITCH_NUM-1:0] shadow [0:STAGE_NUM-1];

    logic accept;
    logic at_last;
    logic frame_err;
    logic frame_ok_last;

    assign accept        = cfg_valid && cfg_ready;
    assign at_last       = (cfg_idx == LAST_IDX);
    // Error when the last flag disagrees with the index position.
    assign frame_err     = accept && (at_last ^ cfg_last);
    assign frame_ok_last = accept && at_last && cfg_last;
    assign state_dbg     = state;

`ifdef BENES_CFG_AUTOSWAP_EN
    logic unused_swap_en;
    assign unused_swap_en = swap_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            cfg_idx      <= '0;
            cfg_ready    <= 1'b0;
            active_valid <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            for (int k = 0; k < STAGE_NUM; k++) begin
                shadow[k]       <= '0;
                o_switch_set[k] <= '0;
            end
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;

            if (accept) begin
                shadow[cfg_idx] <= cfg_data;
            end

            if (frame_err) begin
                cfg_idx <= '0;
                cfg_err <= 1'b1;
            end else if (accept && !at_last) begin
                cfg_idx <= cfg_idx + 1'b1;
            end else if (frame_ok_last) begin
                cfg_idx <= '0;
            end

`ifdef BENES_CFG_AUTOSWAP_EN
            state     <= LOAD;
            cfg_ready <= 1'b1;
            // The final stage comes straight from the bus since shadow is written on this same edge.
            if (frame_ok_last) begin
                for (int k = 0; k < STAGE_NUM - 1; k++) begin
                    o_switch_set[k] <= shadow[k];
                end
                o_switch_set[STAGE_NUM-1] <= cfg_data;
                active_valid <= 1'b1;
                cfg_done     <= 1'b1;
            end
`else
            case (state)
                LOAD: begin
                    if (frame_ok_last) begin
                        state     <= WAIT_SWAP;
                        cfg_ready <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                WAIT_SWAP: begin
                    cfg_ready <= 1'b0;
                    if (swap_en) begin
                        for (int k = 0; k < STAGE_NUM; k++) begin
                            o_switch_set[k] <= shadow[k];
                        end
                        active_valid <= 1'b1;
                        cfg_done     <= 1'b1;
                        cfg_ready    <= 1'b1;
                        state        <= LOAD;
                    end
                end
                default: begin
                    state     <= LOAD;
                    cfg_ready <= 1'b0;
                end
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Self-checking bench for benes_cfg_loader (SIZE=32, 9 stages of 16 switches).
module tb_benes_cfg_loader;

    localparam int SIZE = 32;
    localparam int SW   = SIZE / 2;
    localparam int SN   = 2 * $clog2(SIZE) - 1;
    localparam int W    = SW * SN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [SW-1:0] cfg_data = '0;
    logic          cfg_last = 1'b0;
    logic          swap_en = 1'b0;
    logic [SW-1:0] o_switch_set [0:SN-1];
    logic          active_valid;
    logic          cfg_done;
    logic          cfg_err;
    logic [0:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_active = '0;

    benes_cfg_loader #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .swap_en(swap_en),
        .o_switch_set(o_switch_set), .active_valid(active_valid),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] flat_active();
        logic [W-1:0] f;
        for (int k = 0; k < SN; k++) f[k*SW +: SW] = o_switch_set[k];
        return f;
    endfunction

    // scoreboard: every cfg_done pops one expected configuration; otherwise active must hold
    always @(negedge clk) begin
        if (rst) begin
            last_active = '0;
        end else begin
            checks++;
            if (cfg_done && cfg_err) begin
                errors++;
                $display("FAIL done_err_overlap: done=%b err=%b, required not both high", cfg_done, cfg_err);
            end
            if (cfg_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: cfg_done with no configuration expected");
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (flat_active() !== e) begin
                        errors++;
                        $display("FAIL swap_contents: got %h, required %h", flat_active(), e);
                    end
                end
                last_active = flat_active();
            end else if (flat_active() !== last_active) begin
                errors++;
                $display("FAIL active_hold: got %h, required %h", flat_active(), last_active);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [SW-1:0] d, input logic l);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            errors++;
            $display("FAIL ready_timeout: cfg_ready=0 after %0d cycles, required 1", n);
        end
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic load_cfg(input logic [W-1:0] c, input bit random_gaps);
        for (int k = 0; k < SN; k++) begin
            while (random_gaps && $urandom_range(0, 1) == 1) begin
                cfg_valid = 1'b0;
                cfg_data  = SW'($urandom);
                tick();
            end
            send_word(c[k*SW +: SW], k == SN - 1);
        end
    endtask

    task automatic rand_cfg(output logic [W-1:0] c);
        for (int k = 0; k < SN; k++) c[k*SW +: SW] = SW'($urandom);
    endtask

    task automatic do_swap(input logic [W-1:0] c);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready: got %b, required 0", cfg_ready);
        end
        exp_q.push_back(c);
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        checks += 3;
        if (cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL swap_done: got %b, required 1", cfg_done);
        end
        if (active_valid !== 1'b1) begin
            errors++;
            $display("FAIL swap_active_valid: got %b, required 1", active_valid);
        end
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL swap_ready: got %b, required 1", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b, required 0", cfg_done);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 5;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL %s_ready: got %b, required 0", tag, cfg_ready); end
        if (flat_active() !== '0) begin errors++; $display("FAIL %s_switch: got %h, required 0", tag, flat_active()); end
        if (active_valid !== 1'b0) begin errors++; $display("FAIL %s_active_valid: got %b, required 0", tag, active_valid); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b, required 0", tag, cfg_done); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b, required 0", tag, cfg_err); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b, required 0", cfg_ready); end
        tick();
        checks += 2;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b, required 1", cfg_ready); end
        if (active_valid !== 1'b0) begin errors++; $display("FAIL reset_av_after: got %b, required 0", active_valid); end
    endtask

`ifndef BENES_CFG_AUTOSWAP_EN
    task automatic test_gated_swap();
        logic [W-1:0] c;
        logic [SW-1:0] one;
        one = 1;
        for (int k = 0; k < SN; k++) c[k*SW +: SW] = one << k;
        load_cfg(c, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (cfg_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_%0d: got %b, required 0", i, cfg_ready); end
            if (flat_active() !== '0) begin errors++; $display("FAIL wait_switch_%0d: got %h, required 0", i, flat_active()); end
            cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        do_swap(c);
    endtask

    task automatic test_early_last();
        logic [W-1:0] c;
        swap_en = 1'b1;
        for (int k = 0; k < 4; k++) send_word(SW'($urandom), k == 3);
        checks += 2;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b, required 1", cfg_err); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL early_ready: got %b, required 1", cfg_ready); end
        tick();
        swap_en = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL early_err_pulse: got %b, required 0", cfg_err); end
        rand_cfg(c);
        load_cfg(c, 1'b0);
        repeat (2) tick();
        do_swap(c);
    endtask

    task automatic test_late_last();
        logic [W-1:0] c;
        for (int k = 0; k < SN; k++) send_word(SW'($urandom), 1'b0);
        checks += 2;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL late_err: got %b, required 1", cfg_err); end
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL late_ready: got %b, required 1", cfg_ready); end
        rand_cfg(c);
        load_cfg(c, 1'b1);
        do_swap(c);
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] c;
        for (int k = 0; k < 5; k++) send_word(SW'($urandom), 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick();
        rand_cfg(c);
        load_cfg(c, 1'b0);
        do_swap(c);
    endtask
`else
    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        rand_cfg(a);
        rand_cfg(b);
        cfg_valid = 1'b1;
        for (int n = 0; n < 2 * SN; n++) begin
            cfg_data = (n < SN) ? a[n*SW +: SW] : b[(n-SN)*SW +: SW];
            cfg_last = (n == SN - 1) || (n == 2 * SN - 1);
            if (n == SN - 1) exp_q.push_back(a);
            if (n == 2 * SN - 1) exp_q.push_back(b);
            checks++;
            if (cfg_ready !== 1'b1) begin errors++; $display("FAIL auto_ready_%0d: got %b, required 1", n, cfg_ready); end
            tick();
            if (n == SN - 1 || n == 2 * SN - 1) begin
                checks += 2;
                if (cfg_done !== 1'b1) begin errors++; $display("FAIL auto_done_%0d: got %b, required 1", n, cfg_done); end
                if (flat_active() !== ((n < SN) ? a : b)) begin
                    errors++;
                    $display("FAIL auto_visible_%0d: got %h, required %h", n, flat_active(), (n < SN) ? a : b);
                end
            end
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
`ifndef BENES_CFG_AUTOSWAP_EN
        test_gated_swap();
        test_early_last();
        test_late_last();
        test_rst_mid();
`else
        test_back_to_back();
`endif
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d configurations never swapped in, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/benes_cfg_loader.md
# benes_cfg_loader

Configuration source for the Benes permutation network: accepts a stream of per-stage switch-setting words over a valid/ready handshake and drives the `switch_set` inputs of every `stage_module` / `type_stage_module` instance in the network. Words are written into a shadow bank. The shadow bank is copied atomically into the active bank only at a network-safe point. This lets a new permutation load while the current one keeps routing data.

## Interface
- `SIZE`, 32, network port count (power of two, ≥ 4)
- `SWITCH_NUM`, SIZE/2, switches per stage; width of one config word
- `STAGE_NUM`, 2*$clog2(SIZE)-1, stages in the network; words per configuration
- `clk`  input  1  clock; all state on rising edge
- `rst`  input  1  reset; asynchronous, active-high
- `cfg_valid`  input  1  config word present
- `cfg_ready`  output  1  loader accepts a word this cycle
- `cfg_data`  input  SWITCH_NUM  switch bits for stage `cfg_idx` (bit i drives switch i)
- `cfg_last`  input  1  marks the final word of a configuration
- `swap_en`  input  1  network is idle; shadow→active copy permitted
- `o_switch_set`  output  SWITCH_NUM × [0:STAGE_NUM-1]  active switch settings; element k goes to stage k
- `active_valid`  output  1  at least one complete configuration is active
- `cfg_done`  output  1  one-cycle pulse: new configuration now visible on `o_switch_set`
- `cfg_err`  output  1  one-cycle pulse: framing error, shadow discarded

## Operation
- States: LOAD, WAIT_SWAP.
- Internal `cfg_idx` counter: $clog2(STAGE_NUM) bits, 0..STAGE_NUM-1.
- Shadow bank: STAGE_NUM × SWITCH_NUM registers. Active bank: same size, drives `o_switch_set` directly with no combinational path from inputs.
- LOAD:
  - `cfg_ready`=1.
  - An accepted word (valid&&ready) writes `shadow[cfg_idx]`.
  - If `cfg_idx`<STAGE_NUM-1 and `cfg_last`=0: `cfg_idx`++.
  - If `cfg_idx`==STAGE_NUM-1 and `cfg_last`=1: `cfg_idx`←0, go to WAIT_SWAP.
  - Framing error is `cfg_last`=1 before the final index, or `cfg_last`=0 at the final index. On a framing error: `cfg_err` pulses next cycle, `cfg_idx`←0, stay in LOAD. Partial shadow contents are ignored and overwritten by the next load. The active bank is untouched.
- WAIT_SWAP:
  - `cfg_ready`=0; `cfg_valid` is ignored.
  - On `swap_en`=1: active←shadow (all stages in the same edge), `active_valid`←1, `cfg_done` pulses, return to LOAD.
- `o_switch_set` never shows a mixture of two configurations.

## Timing
- Reset values:
  - `cfg_ready`=0, `o_switch_set`=all 0 (every switch bar/straight), `active_valid`=0, `cfg_done`=0, `cfg_err`=0.
  - State LOAD, `cfg_idx`=0, shadow=0.
- `cfg_ready` is registered. It rises on the first clock edge after `rst` deasserts.
- Last word accepted at edge N: `cfg_ready`=0 from N+1.
- Swap: `swap_en` sampled high at edge M in WAIT_SWAP. New `o_switch_set`, `cfg_done`=1 and `active_valid`=1 all appear after edge M. `cfg_ready`=1 after edge M.
- Minimum configuration period is STAGE_NUM+1 cycles, given `cfg_valid` and `swap_en` held high.
- `swap_en` high in LOAD has no effect.
- `cfg_err` appears the cycle after the offending word is accepted.
- `rst` mid-load or in WAIT_SWAP clears everything immediately, including the active bank. The pending configuration is lost.
- `cfg_done` and `cfg_err` are never high together.

## Configuration
- `BENES_CFG_AUTOSWAP_EN` defined:
  - WAIT_SWAP is removed and `swap_en` is ignored.
  - The edge that accepts a correctly framed last word copies active←{shadow[0..STAGE_NUM-2], `cfg_data`}. `cfg_done` pulses the next cycle.
  - `cfg_ready` stays 1 continuously, so the period is STAGE_NUM cycles.
- Undefined: behaviour as in Operation (swap gated by `swap_en`).

## Test plan
- Reset release, SIZE=32 (STAGE_NUM=9): `cfg_ready` 0→1 one edge after deassert; `o_switch_set` all 0; `active_valid`=0.
- Stream 9 words 16'h0001<<k (k=0..8), `cfg_last` on the 9th word, `swap_en`=0 for 5 cycles then 1: `o_switch_set` stays 0 until the cycle after the `swap_en` edge, then element k=16'h0001<<k; `cfg_done` is a single-cycle pulse; `cfg_ready` is 0 throughout the wait.
- `cfg_last` asserted on the 4th word: `cfg_err` pulses; a following valid 9-word load swaps in correctly; the previous active configuration holds until that swap.
- 9th word sent with `cfg_last`=0: `cfg_err` pulses, no swap; `cfg_valid` toggled randomly during a correct load: only accepted words are stored, in order.
- `rst` pulsed after 5 words of a second configuration: all outputs return to reset values; a fresh 9-word load succeeds.
- `BENES_CFG_AUTOSWAP_EN` build, back-to-back configurations A then B with `cfg_valid` held high: A visible 1 cycle after its last word; B visible 9 cycles later; no cycle with a mix of A and B.
